prod_col_acc: RTL and testbench

Product-scanning column accumulator sitting directly downstream of the 128×128 pipelined multiplier in the IDDMM datapath. It takes the multiplier's 256-bit product stream, realigns per-beat control tags issued at operand time, and sums all partial products of one column into a guarded accumulator. At each column boundary it emits the low 128-bit result word and carries the remainder into the next column. At the end of a multiplication it drains the final high word.

---
 rtl/iddmm_pkg.sv | 23 ++
 rtl/tag_delay.sv | 26 ++
 rtl/prod_col_acc.sv | 103 ++++++++++
 tb/tb_prod_col_acc.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/iddmm_pkg.sv
// rtl/iddmm_pkg.sv - shared IDDMM datapath constants, column tag type and FSM states
package iddmm_pkg;

    localparam int DW       = 128;
    localparam int MULT_LAT = 10;

    typedef struct packed {
        logic valid;
        logic first;
        logic eoc;
        logic last;
    } col_tag_t;

    typedef enum logic {
        ST_ACC   = 1'b0,
        ST_DRAIN = 1'b1
    } acc_state_t;

    function automatic int acc_width(input int dw, input int guard);
        return 2 * dw + guard;
    endfunction

endpackage

// File: rtl/tag_delay.sv
// rtl/tag_delay.sv - LAT-stage shift register aligning column tags with multiplier products
module tag_delay
    import iddmm_pkg::*;
#(
    parameter int LAT = MULT_LAT
) (
    input  logic     clk,
    input  logic     rst_n,
    input  col_tag_t tag_issue,
    output col_tag_t tag_align
);

    col_tag_t stage [LAT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) stage[i] <= '0;
        end else begin
            stage[0] <= tag_issue;
            for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
        end
    end

    assign tag_align = stage[LAT-1];

endmodule

// File: rtl/prod_col_acc.sv
// rtl/prod_col_acc.sv - product-scanning column accumulator behind the pipelined multiplier
module prod_col_acc
    import iddmm_pkg::*;
#(
    parameter int DW    = iddmm_pkg::DW,
    parameter int LAT   = MULT_LAT,
    parameter int GUARD = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tag_valid,
    input  logic          tag_first,
    input  logic          tag_eoc,
    input  logic          tag_last,
    input  logic [DW-1:0] prod_lo,
    input  logic [DW-1:0] prod_hi,
    output logic          out_valid,
    output logic [DW-1:0] out_word,
    output logic          out_last,
    output logic          err
);

    localparam int AW = acc_width(DW, GUARD);

    col_tag_t   tag_issue;
    col_tag_t   b;
    acc_state_t state, state_d;
    logic [AW-1:0] acc, acc_d, base;
    logic [AW:0]   prod_ext, sum;
    logic          out_valid_d, out_last_d, err_set;
    logic [DW-1:0] out_word_d;

    // Qualify side-band fields with valid so idle cycles never carry stray flags.
    assign tag_issue = {tag_valid, tag_valid & tag_first,
                        tag_valid & tag_eoc, tag_valid & tag_last};

    tag_delay #(.LAT(LAT)) u_tag_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .tag_issue (tag_issue),
        .tag_align (b)
    );

    always_comb begin
        base                 = b.first ? '0 : acc;
        prod_ext             = '0;
        prod_ext[2*DW-1:0]   = {prod_hi, prod_lo};
        sum                  = {1'b0, base} + prod_ext;

        state_d     = state;
        acc_d       = acc;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_word_d  = out_word;
        err_set     = 1'b0;

        case (state)
            ST_ACC: begin
                if (b.valid) begin
                    err_set = sum[AW];
                    if (b.eoc || b.last) begin
                        out_word_d           = sum[DW-1:0];
                        out_valid_d          = 1'b1;
                        acc_d                = '0;
                        acc_d[AW-DW-1:0]     = sum[AW-1:DW];
                    end else begin
                        acc_d = sum[AW-1:0];
                    end
                    if (b.last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A beat landing here violates the idle-cycle rule; it is dropped.
                out_word_d  = acc[DW-1:0];
                out_valid_d = 1'b1;
                out_last_d  = 1'b1;
                err_set     = (|acc[AW-1:DW]) | b.valid;
                acc_d       = '0;
                state_d     = ST_ACC;
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_ACC;
            acc       <= '0;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            acc       <= acc_d;
            out_valid <= out_valid_d;
            out_word  <= out_word_d;
            out_last  <= out_last_d;
            err       <= err | err_set;
        end
    end

endmodule

// File: tb/tb_prod_col_acc.sv
// tb/tb_prod_col_acc.sv - directed self-checking bench for prod_col_acc
module tb_prod_col_acc;

    localparam int DW  = 128;
    localparam int LAT = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tag_valid, tag_first, tag_eoc, tag_last;
    logic [DW-1:0] mult_hi, mult_lo;
    logic [DW-1:0] prod_hi, prod_lo;
    logic          out_valid, out_last, err;
    logic [DW-1:0] out_word;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int bad_last = 0;

    typedef struct packed {
        logic [31:0]   c;
        logic [DW-1:0] w;
        logic          l;
    } ev_t;
    ev_t outq [$];

    logic [DW-1:0] ph [LAT];
    logic [DW-1:0] pl [LAT];

    prod_col_acc #(.DW(DW), .LAT(LAT), .GUARD(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tag_valid (tag_valid),
        .tag_first (tag_first),
        .tag_eoc   (tag_eoc),
        .tag_last  (tag_last),
        .prod_lo   (prod_lo),
        .prod_hi   (prod_hi),
        .out_valid (out_valid),
        .out_word  (out_word),
        .out_last  (out_last),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier stand-in: the product issued with a tag reappears LAT cycles later.
    always @(posedge clk) begin
        ph[0] <= mult_hi;
        pl[0] <= mult_lo;
        for (int k = 1; k < LAT; k++) begin
            ph[k] <= ph[k-1];
            pl[k] <= pl[k-1];
        end
    end
    assign prod_hi = ph[LAT-1];
    assign prod_lo = pl[LAT-1];

    always @(negedge clk) begin
        if (out_valid) outq.push_back({32'(cyc), out_word, out_last});
        if (out_last && !out_valid) bad_last++;
    end

    task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, got, exp);
        end
    endtask

    task automatic expect_out(input string name, input logic [DW-1:0] w, input logic l, input int c);
        ev_t e;
        logic [191:0] g, x;
        if (outq.size() == 0) e = '1;
        else e = outq.pop_front();
        g = '0; g[160:0] = e;
        x = '0; x[160:0] = {32'(c), w, l};
        check(name, g, x);
    endtask

    task automatic issue(input logic f, input logic eoc, input logic l,
                         input logic [DW-1:0] hi, input logic [DW-1:0] lo);
        tag_valid = 1'b1; tag_first = f; tag_eoc = eoc; tag_last = l;
        mult_hi = hi; mult_lo = lo;
        @(posedge clk); #1;
        tag_valid = 1'b0; tag_first = 1'b0; tag_eoc = 1'b0; tag_last = 1'b0;
        mult_hi = '0; mult_lo = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int c;

    initial begin
        rst_n = 1'b0;
        tag_valid = 1'b0; tag_first = 1'b0; tag_eoc = 1'b0; tag_last = 1'b0;
        mult_hi = '0; mult_lo = '0;
        idle(3);
        check("rst_out_valid", 192'(out_valid), 192'(0));
        check("rst_out_word",  192'(out_word),  192'(0));
        check("rst_out_last",  192'(out_last),  192'(0));
        check("rst_err",       192'(err),       192'(0));
        rst_n = 1'b1;
        idle(LAT + 2);
        check("post_rst_quiet", 192'(outq.size()), 192'(0));

        // Single product {first,last}: hi=1, lo=2
        c = cyc;
        issue(1, 0, 1, 128'd1, 128'd2);
        idle(LAT + 4);
        expect_out("single_lo",    128'd2, 1'b0, c + LAT + 1);
        expect_out("single_drain", 128'd1, 1'b1, c + LAT + 2);
        check("single_err", 192'(err), 192'(0));

        // Column carry across the word boundary
        c = cyc;
        issue(1, 0, 0, 128'd0, ~128'd0);
        issue(0, 1, 0, 128'd0, 128'd1);
        issue(0, 0, 1, 128'd0, 128'd0);
        idle(LAT + 4);
        expect_out("carry_col0",  128'd0, 1'b0, c + 1 + LAT + 1);
        expect_out("carry_col1",  128'd1, 1'b0, c + 2 + LAT + 1);
        expect_out("carry_drain", 128'd0, 1'b1, c + 2 + LAT + 2);

        // 32 all-ones squared products in one column, then a closing column
        c = cyc;
        for (int i = 0; i < 32; i++) issue(i == 0, i == 31, 0, ~128'd1, 128'd1);
        issue(0, 0, 1, 128'd0, 128'd0);
        idle(LAT + 4);
        expect_out("sat32_col",   128'd32,  1'b0, c + 31 + LAT + 1);
        expect_out("sat32_next",  ~128'd63, 1'b0, c + 32 + LAT + 1);
        expect_out("sat32_drain", 128'd31,  1'b1, c + 32 + LAT + 2);
        check("sat32_err", 192'(err), 192'(0));

        // Back-to-back multiplications separated by one idle cycle
        c = cyc;
        issue(1, 0, 1, 128'd5, 128'd7);
        idle(1);
        issue(1, 0, 1, 128'd0, 128'd9);
        idle(LAT + 4);
        expect_out("b2b_a_lo",  128'd7, 1'b0, c + LAT + 1);
        expect_out("b2b_a_hi",  128'd5, 1'b1, c + LAT + 2);
        expect_out("b2b_b_lo",  128'd9, 1'b0, c + 2 + LAT + 1);
        expect_out("b2b_b_hi",  128'd0, 1'b1, c + 2 + LAT + 2);
        check("b2b_err", 192'(err), 192'(0));

        // Reset pulse with a partial column accumulated and a tag in flight
        issue(1, 0, 0, 128'd0, 128'd100);
        idle(LAT + 3);
        issue(0, 1, 0, 128'd0, 128'd3);
        idle(2);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(LAT + 3);
        check("rst_mid_no_out", 192'(outq.size()), 192'(0));
        c = cyc;
        issue(0, 0, 1, 128'd0, 128'd4);
        idle(LAT + 4);
        expect_out("rst_mid_word",  128'd4, 1'b0, c + LAT + 1);
        expect_out("rst_mid_drain", 128'd0, 1'b1, c + LAT + 2);
        check("rst_mid_err", 192'(err), 192'(0));

        // Tag immediately after tag_last lands in DRAIN and is dropped
        c = cyc;
        issue(1, 0, 1, 128'd0, 128'd1);
        issue(1, 1, 0, 128'd0, 128'd50);
        idle(LAT + 4);
        expect_out("drop_word",  128'd1, 1'b0, c + LAT + 1);
        expect_out("drop_drain", 128'd0, 1'b1, c + LAT + 2);
        check("drop_no_extra", 192'(outq.size()), 192'(0));
        check("drop_err",      192'(err), 192'(1));

        check("last_only_with_valid", 192'(bad_last), 192'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
